// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Memory-stage load/store unit for the pipelined MIPS core. Decodes the
// M-stage access, checks alignment and address-map legality, runs one
// req/ack bus transaction per accepted op (any number of wait states), stalls
// the pipeline until it completes and returns sign/zero-extended load data.
//
// Optional feature (compile-time macro): MEM_TIMEOUT_EN
//   defined   : a wait counter runs in BUSY; after MAX_WAIT BUSY cycles with no
//               bus_ack the access completes with bus_err=1 and rdata=0.
//   undefined : BUSY waits forever, bus_err is tied low, no counter is built.
//
// Ports
//   clk, reset             clock (rising edge), asynchronous active-high reset
//   req_valid, op, addr,   M-stage memory op; held stable while stall=1
//   wdata, overflow
//   stall                  freeze F/D/E/M
//   done, rdata, bus_err   one-cycle completion pulse with its load data/status
//   adel, ades             load/store address exception (IDLE only)
//   bus_req, bus_we,       bus request, held until bus_ack; all bus outputs
//   bus_addr, bus_byteen,  are registered and stable during the request
//   bus_wdata
//   bus_rdata, bus_ack     bus response; bus_rdata sampled with bus_ack
// -----------------------------------------------------------------------------
module mem_access_unit #(
  parameter logic [31:0] DM_END    = 32'h0000_2FFF,
  parameter logic [31:0] DEV0_BASE = 32'h0000_7F00,
  parameter logic [31:0] DEV1_BASE = 32'h0000_7F10,
  parameter logic [31:0] IRQ_BASE  = 32'h0000_7F20,
  parameter int          MAX_WAIT  = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        overflow,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        bus_err,
  output logic        adel,
  output logic        ades,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_byteen,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LH  = 3'd1,
    OP_LHU = 3'd2,
    OP_LB  = 3'd3,
    OP_LBU = 3'd4,
    OP_SW  = 3'd5,
    OP_SH  = 3'd6,
    OP_SB  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // Elaboration-time sanity check on the watchdog limit.
  if (MAX_WAIT < 1) begin : g_bad_max_wait
    $error("mem_access_unit: MAX_WAIT must be >= 1");
  end

  state_e      state;
  op_e         op_d;
  op_e         op_q;
  logic [1:0]  off_q;

  // ---------------------------------------------------------------------------
  // Access decode
  // ---------------------------------------------------------------------------
  logic is_store, is_word, is_half;
  logic in_ram, in_dev0, in_dev1, in_irq, in_ro, legal, high_region;
  logic misalign, common_fault, fault, accept;

  assign op_d     = op_e'(op);
  assign is_store = (op_d == OP_SW) || (op_d == OP_SH) || (op_d == OP_SB);
  assign is_word  = (op_d == OP_LW) || (op_d == OP_SW);
  assign is_half  = (op_d == OP_LH) || (op_d == OP_LHU) || (op_d == OP_SH);

  assign in_ram  = (addr <= DM_END);
  assign in_dev0 = (addr >= DEV0_BASE) && (addr <= DEV0_BASE + 32'd11);
  assign in_dev1 = (addr >= DEV1_BASE) && (addr <= DEV1_BASE + 32'd11);
  assign in_irq  = (addr >= IRQ_BASE)  && (addr <= IRQ_BASE  + 32'd3);
  assign legal   = in_ram || in_dev0 || in_dev1 || in_irq;

  // Offsets +8..+11 of each device window are a read-only count register.
  assign in_ro = ((addr >= DEV0_BASE + 32'd8) && (addr <= DEV0_BASE + 32'd11)) ||
                 ((addr >= DEV1_BASE + 32'd8) && (addr <= DEV1_BASE + 32'd11));

  // Everything from DEV0_BASE upward is word-access-only I/O space.
  assign high_region = (addr >= DEV0_BASE);

  assign misalign     = (is_word && (addr[1:0] != 2'b00)) || (is_half && addr[0]);
  assign common_fault = misalign || overflow || !legal || (!is_word && high_region);
  assign fault        = common_fault || (is_store && in_ro);

  assign accept = (state == S_IDLE) && req_valid && !fault;

  // Exceptions and stall are combinational and forced low while reset is held
  // so the pipeline never sees a stale request during reset.
  assign adel  = !reset && (state == S_IDLE) && req_valid && !is_store && common_fault;
  assign ades  = !reset && (state == S_IDLE) && req_valid &&  is_store && fault;
  assign stall = !reset && (accept || (state == S_BUSY));

  // ---------------------------------------------------------------------------
  // Store lane steering (from the live inputs, captured on accept)
  // ---------------------------------------------------------------------------
  logic [3:0]  byteen_n;
  logic [31:0] wdata_n;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned -- otherwise synthesis infers a latch.
  always_comb begin
    byteen_n = 4'b0000;
    wdata_n  = 32'h0;
    case (op_d)
      OP_SW: begin
        byteen_n = 4'b1111;
        wdata_n  = wdata;
      end
      OP_SH: begin
        if (addr[1]) begin
          byteen_n = 4'b1100;
          wdata_n  = wdata << 16;
        end else begin
          byteen_n = 4'b0011;
          wdata_n  = wdata;
        end
      end
      OP_SB: begin
        byteen_n = 4'b0001 << addr[1:0];
        wdata_n  = wdata << {addr[1:0], 3'b000};
      end
      default: begin
        byteen_n = 4'b0000;
        wdata_n  = 32'h0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Load extraction (from the captured op/offset and the returning bus data)
  // ---------------------------------------------------------------------------
  logic [15:0] half_sel;
  logic [7:0]  byte_sel;
  logic [31:0] load_data;

  always_comb begin
    half_sel = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (off_q)
      2'd0:    byte_sel = bus_rdata[7:0];
      2'd1:    byte_sel = bus_rdata[15:8];
      2'd2:    byte_sel = bus_rdata[23:16];
      default: byte_sel = bus_rdata[31:24];
    endcase
    case (op_q)
      OP_LW:   load_data = bus_rdata;
      OP_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_data = {16'h0, half_sel};
      OP_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_data = {24'h0, byte_sel};
      default: load_data = 32'h0;   // stores complete with rdata = 0
    endcase
  end

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);

  logic [CNT_W-1:0] wait_cnt;
  logic             timeout;

  // wait_cnt holds the number of completed BUSY cycles; timeout fires in the
  // MAX_WAIT-th BUSY cycle, so bus_req is high for exactly MAX_WAIT cycles.
  assign timeout = (wait_cnt == CNT_W'(MAX_WAIT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if ((state == S_BUSY) && !bus_ack && !timeout) begin
      wait_cnt <= wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end
`else
  assign bus_err = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      op_q       <= OP_LW;
      off_q      <= 2'b00;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= 32'h0;
      bus_byteen <= 4'b0000;
      bus_wdata  <= 32'h0;
      rdata      <= 32'h0;
      done       <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      bus_err    <= 1'b0;
`endif
    end else begin
      // done/bus_err are single-cycle pulses accompanying the RESP state.
      done <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      bus_err <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q       <= op_d;
            off_q      <= addr[1:0];
            bus_addr   <= {addr[31:2], 2'b00};
            bus_byteen <= byteen_n;
            bus_wdata  <= wdata_n;
            bus_we     <= is_store;
            bus_req    <= 1'b1;
            state      <= S_BUSY;
          end
        end

        S_BUSY: begin
          // An ack in the timeout cycle wins: it is checked first.
          if (bus_ack) begin
            rdata   <= load_data;
            bus_req <= 1'b0;
            done    <= 1'b1;
            state   <= S_RESP;
          end
`ifdef MEM_TIMEOUT_EN
          else if (timeout) begin
            rdata   <= 32'h0;
            bus_req <= 1'b0;
            done    <= 1'b1;
            bus_err <= 1'b1;
            state   <= S_RESP;
          end
`endif
        end

        S_RESP: begin
          // req_valid still shows the completed op this cycle; never re-accept.
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//
// Self-checking bench for mem_access_unit (default parameters). A table of
// directed single-access vectors is run through one transaction task; reset,
// back-to-back and hung-bus corner cases are hand-written sequences. Inputs
// are driven 1 ns after the rising edge, outputs sampled 3 ns after it.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [2:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        overflow;
  logic        stall;
  logic        done;
  logic [31:0] rdata;
  logic        bus_err;
  logic        adel;
  logic        ades;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_byteen;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3,
                         LBU = 3'd4, SW = 3'd5, SH = 3'd6, SB = 3'd7;

  mem_access_unit dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .op         (op),
    .addr       (addr),
    .wdata      (wdata),
    .overflow   (overflow),
    .stall      (stall),
    .done       (done),
    .rdata      (rdata),
    .bus_err    (bus_err),
    .adel       (adel),
    .ades       (ades),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_byteen (bus_byteen),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .bus_ack    (bus_ack)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge (input-drive point).
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ovf;
    logic [31:0] brdata;
    int          waits;
    logic        e_adel;
    logic        e_ades;
    logic [3:0]  e_be;
    logic [31:0] e_bwdata;
    logic [31:0] e_baddr;
    logic        e_we;
    logic [31:0] e_rdata;
  } vec_t;

  function automatic vec_t mk(string name, logic [2:0] o, logic [31:0] a,
                              logic [31:0] wd, logic ovf, logic [31:0] brd,
                              int waits, logic e_adel, logic e_ades,
                              logic [3:0] e_be, logic [31:0] e_bwd,
                              logic [31:0] e_ba, logic e_we, logic [31:0] e_rd);
    vec_t v;
    v.name = name; v.op = o; v.addr = a; v.wdata = wd; v.ovf = ovf;
    v.brdata = brd; v.waits = waits; v.e_adel = e_adel; v.e_ades = e_ades;
    v.e_be = e_be; v.e_bwdata = e_bwd; v.e_baddr = e_ba; v.e_we = e_we;
    v.e_rdata = e_rd;
    return v;
  endfunction

  // One complete access: present op, check exception/stall, then either
  // confirm no bus cycle (faulting op) or walk BUSY/RESP and check results.
  task automatic run_vec(input vec_t v);
    int stall_cnt;
    stall_cnt = 0;
    tick();
    req_valid = 1'b1; op = v.op; addr = v.addr; wdata = v.wdata;
    overflow = v.ovf; bus_ack = 1'b0; bus_rdata = 32'h0;
    #2;
    check({v.name, " adel"}, {31'h0, adel}, {31'h0, v.e_adel});
    check({v.name, " ades"}, {31'h0, ades}, {31'h0, v.e_ades});
    if (v.e_adel || v.e_ades) begin
      check({v.name, " stall on fault"}, {31'h0, stall}, 32'h0);
      tick();
      #2;
      check({v.name, " no bus_req on fault"}, {31'h0, bus_req}, 32'h0);
      req_valid = 1'b0;
      overflow  = 1'b0;
      return;
    end
    stall_cnt += int'(stall);
    tick();
    for (int w = 0; w <= v.waits; w++) begin
      bus_ack   = (w == v.waits);
      bus_rdata = (w == v.waits) ? v.brdata : 32'hDEAD_0000;
      #2;
      stall_cnt += int'(stall);
      check({v.name, " bus_req"},    {31'h0, bus_req},    32'h1);
      check({v.name, " bus_addr"},   bus_addr,             v.e_baddr);
      check({v.name, " bus_byteen"}, {28'h0, bus_byteen}, {28'h0, v.e_be});
      check({v.name, " bus_we"},     {31'h0, bus_we},     {31'h0, v.e_we});
      if (v.e_we) check({v.name, " bus_wdata"}, bus_wdata, v.e_bwdata);
      check({v.name, " done early"}, {31'h0, done},       32'h0);
      tick();
    end
    bus_ack = 1'b0;
    #2;
    check({v.name, " done"},       {31'h0, done},    32'h1);
    check({v.name, " rdata"},      rdata,            v.e_rdata);
    check({v.name, " bus_err"},    {31'h0, bus_err}, 32'h0);
    check({v.name, " stall resp"}, {31'h0, stall},   32'h0);
    check({v.name, " req dropped"},{31'h0, bus_req}, 32'h0);
    check({v.name, " stall cycles"}, stall_cnt, v.waits + 2);
    tick();
    req_valid = 1'b0;
    overflow  = 1'b0;
    #2;
    check({v.name, " done pulse"}, {31'h0, done}, 32'h0);
  endtask

  vec_t vecs[$];
  int   cnt;

  initial begin : watchdog
    #2_000_000;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    // --- table of single-access vectors -------------------------------------
    //               name      op   addr          wdata         ovf  bus_rdata     w  adel ades be       bus_wdata     bus_addr      we  rdata
    vecs.push_back(mk("lb",    LB,  32'h0000_0013, 32'h0,        0, 32'h80FF_0000, 2, 0, 0, 4'b0000, 32'h0,        32'h0000_0010, 0, 32'hFFFF_FF80));
    vecs.push_back(mk("lbu",   LBU, 32'h0000_0013, 32'h0,        0, 32'h80FF_0000, 2, 0, 0, 4'b0000, 32'h0,        32'h0000_0010, 0, 32'h0000_0080));
    vecs.push_back(mk("sh_hi", SH,  32'h0000_0102, 32'h1234_ABCD, 0, 32'h0,        1, 0, 0, 4'b1100, 32'hABCD_0000, 32'h0000_0100, 1, 32'h0));
    vecs.push_back(mk("sh_lo", SH,  32'h0000_0100, 32'h1234_ABCD, 0, 32'h0,        0, 0, 0, 4'b0011, 32'h1234_ABCD, 32'h0000_0100, 1, 32'h0));
    vecs.push_back(mk("lh",    LH,  32'h0000_0002, 32'h0,        0, 32'h8001_1234, 0, 0, 0, 4'b0000, 32'h0,        32'h0000_0000, 0, 32'hFFFF_8001));
    vecs.push_back(mk("lhu",   LHU, 32'h0000_0200, 32'h0,        0, 32'h8001_F234, 0, 0, 0, 4'b0000, 32'h0,        32'h0000_0200, 0, 32'h0000_F234));
    vecs.push_back(mk("sb1",   SB,  32'h0000_0001, 32'h0000_00A5, 0, 32'h0,        0, 0, 0, 4'b0010, 32'h0000_A500, 32'h0000_0000, 1, 32'h0));
    vecs.push_back(mk("sb_end",SB,  32'h0000_2FFF, 32'h0000_0011, 0, 32'h0,        0, 0, 0, 4'b1000, 32'h1100_0000, 32'h0000_2FFC, 1, 32'h0));
    vecs.push_back(mk("lw_end",LW,  32'h0000_2FFC, 32'h0,        0, 32'hA5A5_5A5A, 0, 0, 0, 4'b0000, 32'h0,        32'h0000_2FFC, 0, 32'hA5A5_5A5A));
    vecs.push_back(mk("sw_d1", SW,  32'h0000_7F14, 32'hDEAD_BEEF, 0, 32'h0,        0, 0, 0, 4'b1111, 32'hDEAD_BEEF, 32'h0000_7F14, 1, 32'h0));
    vecs.push_back(mk("lw_cnt",LW,  32'h0000_7F18, 32'h0,        0, 32'h1234_5678, 3, 0, 0, 4'b0000, 32'h0,        32'h0000_7F18, 0, 32'h1234_5678));
    vecs.push_back(mk("sw_irq",SW,  32'h0000_7F20, 32'h0000_0001, 0, 32'h0,        0, 0, 0, 4'b1111, 32'h0000_0001, 32'h0000_7F20, 1, 32'h0));
    vecs.push_back(mk("lw_mis",LW,  32'h0000_0006, 32'h0,        0, 32'h0,        0, 1, 0, 4'b0000, 32'h0,        32'h0,         0, 32'h0));
    vecs.push_back(mk("sw_ro", SW,  32'h0000_7F08, 32'h0,        0, 32'h0,        0, 0, 1, 4'b0000, 32'h0,        32'h0,         0, 32'h0));
    vecs.push_back(mk("sb_dev",SB,  32'h0000_7F00, 32'h0,        0, 32'h0,        0, 0, 1, 4'b0000, 32'h0,        32'h0,         0, 32'h0));
    vecs.push_back(mk("lw_gap",LW,  32'h0000_3000, 32'h0,        0, 32'h0,        0, 1, 0, 4'b0000, 32'h0,        32'h0,         0, 32'h0));
    vecs.push_back(mk("lw_ovf",LW,  32'h0000_0100, 32'h0,        1, 32'h0,        0, 1, 0, 4'b0000, 32'h0,        32'h0,         0, 32'h0));
    vecs.push_back(mk("lh_dev",LH,  32'h0000_7F00, 32'h0,        0, 32'h0,        0, 1, 0, 4'b0000, 32'h0,        32'h0,         0, 32'h0));
    vecs.push_back(mk("sh_mis",SH,  32'h0000_0103, 32'h0,        0, 32'h0,        0, 0, 1, 4'b0000, 32'h0,        32'h0,         0, 32'h0));
    vecs.push_back(mk("lw_d0x",LW,  32'h0000_7F0C, 32'h0,        0, 32'h0,        0, 1, 0, 4'b0000, 32'h0,        32'h0,         0, 32'h0));
    vecs.push_back(mk("lw_irx",LW,  32'h0000_7F24, 32'h0,        0, 32'h0,        0, 1, 0, 4'b0000, 32'h0,        32'h0,         0, 32'h0));

    // --- reset state (exceptions and stall masked during reset) -------------
    reset = 1'b1; req_valid = 1'b1; op = LW; addr = 32'h0000_0006;
    wdata = 32'h0; overflow = 1'b0; bus_rdata = 32'h0; bus_ack = 1'b0;
    tick(); tick();
    #2;
    check("rst adel",       {31'h0, adel},       32'h0);
    check("rst stall",      {31'h0, stall},      32'h0);
    check("rst bus_req",    {31'h0, bus_req},    32'h0);
    check("rst bus_we",     {31'h0, bus_we},     32'h0);
    check("rst bus_addr",   bus_addr,            32'h0);
    check("rst bus_byteen", {28'h0, bus_byteen}, 32'h0);
    check("rst bus_wdata",  bus_wdata,           32'h0);
    check("rst rdata",      rdata,               32'h0);
    check("rst done",       {31'h0, done},       32'h0);
    check("rst bus_err",    {31'h0, bus_err},    32'h0);
    req_valid = 1'b0;
    tick();
    reset = 1'b0;

    // bus_ack while IDLE must not produce a completion
    tick();
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    #2;
    check("idle ack ignored done",  {31'h0, done},    32'h0);
    check("idle ack ignored stall", {31'h0, stall},   32'h0);

    // --- table-driven vectors ------------------------------------------------
    foreach (vecs[i]) run_vec(vecs[i]);

    // --- back-to-back SW 0x4 then LW 0x4, ack held high through RESP --------
    tick();
    req_valid = 1'b1; op = SW; addr = 32'h0000_0004; wdata = 32'hCAFE_F00D;
    #2;
    check("b2b sw accept stall", {31'h0, stall}, 32'h1);
    tick();
    bus_ack = 1'b1;
    #2;
    check("b2b sw bus_req", {31'h0, bus_req}, 32'h1);
    check("b2b sw bus_we",  {31'h0, bus_we},  32'h1);
    tick();
    #2;
    check("b2b resp done",    {31'h0, done},    32'h1);
    check("b2b resp no req",  {31'h0, bus_req}, 32'h0);
    check("b2b resp stall",   {31'h0, stall},   32'h0);
    tick();
    bus_ack = 1'b0; op = LW; addr = 32'h0000_0004;
    #2;
    check("b2b lw accept stall", {31'h0, stall},   32'h1);
    check("b2b idle no req",     {31'h0, bus_req}, 32'h0);
    check("b2b idle done low",   {31'h0, done},    32'h0);
    tick();
    bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D;
    #2;
    check("b2b lw bus_req",  {31'h0, bus_req}, 32'h1);
    check("b2b lw bus_we",   {31'h0, bus_we},  32'h0);
    check("b2b lw bus_addr", bus_addr,         32'h0000_0004);
    check("b2b lw byteen",   {28'h0, bus_byteen}, 32'h0);
    tick();
    bus_ack = 1'b0; req_valid = 1'b0;
    #2;
    check("b2b lw done",  {31'h0, done}, 32'h1);
    check("b2b lw rdata", rdata,         32'hCAFE_F00D);

    // --- reset asserted in BUSY drops bus_req asynchronously ----------------
    tick();
    req_valid = 1'b1; op = LW; addr = 32'h0000_0040;
    tick();
    #2;
    check("mid-rst busy req", {31'h0, bus_req}, 32'h1);
    reset = 1'b1;
    #1;
    check("mid-rst req async", {31'h0, bus_req}, 32'h0);
    check("mid-rst stall",     {31'h0, stall},   32'h0);
    req_valid = 1'b0;
    tick();
    reset = 1'b0;
    #2;
    check("post-rst idle req",  {31'h0, bus_req}, 32'h0);
    check("post-rst no done",   {31'h0, done},    32'h0);
    run_vec(mk("lw0_rst", LW, 32'h0, 32'h0, 0, 32'h0BAD_F00D, 0, 0, 0,
               4'b0000, 32'h0, 32'h0, 0, 32'h0BAD_F00D));

    // --- hung bus: LW with no ack -------------------------------------------
    tick();
    req_valid = 1'b1; op = LW; addr = 32'h0000_0020; bus_ack = 1'b0;
    tick();
`ifdef MEM_TIMEOUT_EN
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      #2;
      if (done) break;
      if (bus_req) cnt++;
      tick();
    end
    check("timeout req cycles", cnt,            15);
    check("timeout done",      {31'h0, done},    32'h1);
    check("timeout bus_err",   {31'h0, bus_err}, 32'h1);
    check("timeout rdata",     rdata,            32'h0);
    check("timeout req low",   {31'h0, bus_req}, 32'h0);
    tick();
    req_valid = 1'b0;
`else
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      #2;
      if (stall && bus_req && !done) cnt++;
      tick();
    end
    check("hang stall cycles", cnt, 100);
    bus_ack = 1'b1; bus_rdata = 32'h5555_AAAA;
    tick();
    bus_ack = 1'b0;
    #2;
    check("hang late done",    {31'h0, done},    32'h1);
    check("hang late rdata",   rdata,            32'h5555_AAAA);
    check("hang bus_err tied", {31'h0, bus_err}, 32'h0);
    tick();
    req_valid = 1'b0;
`endif

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage load/store unit for the pipelined MIPS core; parametrised successor to the combinational memory-stage data extender. Decodes the access, checks alignment and address-map legality, and drives a req/ack data bus that may insert wait states. It stalls the pipeline until the access completes and returns sign- or zero-extended load data. An optional watchdog turns a hung bus access into a bus-error completion.

## Interface
- DM_END, 32'h0000_2FFF, last byte address of data RAM (RAM spans 0..DM_END)
- DEV0_BASE, 32'h0000_7F00, device 0 window (12 bytes, word-only)
- DEV1_BASE, 32'h0000_7F10, device 1 window (12 bytes, word-only)
- IRQ_BASE, 32'h0000_7F20, interrupt-generator window (4 bytes, word-only)
- MAX_WAIT, 15, BUSY cycles allowed before timeout; only used with the watchdog compiled in
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- req_valid  in  1  M-stage instruction is a memory op; held stable while stall=1
- op  in  3  0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU, 5 SW, 6 SH, 7 SB
- addr  in  32  effective address (ALU result)
- wdata  in  32  store data, right-aligned
- overflow  in  1  address computation overflowed
- stall  out  1  freeze F/D/E/M stages
- done  out  1  one-cycle completion pulse
- rdata  out  32  extended load data; valid while done=1
- bus_err  out  1  completion was a timeout; valid while done=1
- adel / ades  out  1 each  load / store address exception
- bus_req  out  1  access request, held until ack
- bus_we  out  1  write request
- bus_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- bus_byteen  out  4  byte lanes (stores); 4'b0000 for loads
- bus_wdata  out  32  lane-shifted store data
- bus_rdata  in  32  read data; sampled with bus_ack
- bus_ack  in  1  completion from the bus, one cycle

## Operation
- Legal address: in [0,DM_END], [DEVx_BASE,DEVx_BASE+11], or [IRQ_BASE,IRQ_BASE+3].
- adel (load op): word misaligned (addr[1:0]!=0) | half misaligned (addr[0]) | overflow | illegal address | half/byte load at >= DEV0_BASE.
- ades (store op): the same checks for stores, plus any store to DEVx_BASE+8..+11 (read-only count register).
- adel/ades are combinational, asserted only when state=IDLE & req_valid. A faulting op is not accepted: no bus cycle, stall=0.
- FSM states:
  - IDLE: accept when req_valid & !adel & !ades. Capture op, byte offset, bus_addr/byteen/wdata/we into registers; next state BUSY.
  - BUSY: bus_req=1 with all bus outputs stable. On bus_ack: latch the extended load (0 for stores) into rdata; next state RESP.
  - RESP: done=1, stall=0, req_valid ignored; next state IDLE.
- stall = (IDLE & accept) | BUSY.
- Lane rules:
  - SW: byteen 1111.
  - SH: byteen 1100 if offset[1], data <<16; else 0011.
  - SB: byteen 0001<<offset, data <<(8*offset).
- Load extraction uses the same lane select as the store rules. LH/LB sign-extend; LHU/LBU zero-extend.

## Timing
- Minimum access is 3 cycles: accept at cycle 0, bus_req at cycle 1, ack at cycle 1, done at cycle 2. Each wait state adds one cycle.
- bus_ack in IDLE/RESP is ignored.
- Reset values: state IDLE, bus_req 0, bus_we 0, bus_byteen 0, bus_addr 0, bus_wdata 0, rdata 0, done 0, bus_err 0, wait counter 0.
- stall, adel and ades are forced to 0 while reset is asserted.
- Reset mid-access (BUSY) drops bus_req immediately and the access is abandoned.

## Configuration
- MEM_TIMEOUT_EN defined:
  - The wait counter runs in BUSY.
  - If the counter reaches MAX_WAIT without bus_ack, bus_req drops and the FSM enters RESP with done=1, bus_err=1, rdata=0.
  - An ack arriving in the same cycle as the timeout wins (normal completion).
- MEM_TIMEOUT_EN undefined: BUSY waits indefinitely, bus_err is tied to 0, and no counter is built.

## Test plan
- LB addr 0x0000_0013, bus_rdata 0x80FF_0000, ack after 2 waits -> stall 4 cycles, done at cycle 4, rdata 0xFFFF_FF80; the same access as LBU -> 0x0000_0080.
- SH addr 0x0000_0102, wdata 0x1234_ABCD -> bus_byteen 1100, bus_wdata 0xABCD_0000, bus_addr 0x100, bus_we 1 held until ack.
- LW addr 0x0000_0006 -> adel=1, stall=0, bus_req never asserted; SW addr 0x7F08 -> ades=1; SB addr 0x7F00 -> ades=1; LW addr 0x3000 -> adel=1.
- MEM_TIMEOUT_EN, MAX_WAIT=15, LW with no ack -> bus_req high 15 cycles, then done=1, bus_err=1, rdata 0; with the macro undefined -> stall held for 100 cycles.
- Assert reset while in BUSY -> bus_req=0 asynchronously; after release, a new LW to 0x0 completes normally in 3 cycles.
- Back-to-back SW 0x4 then LW 0x4 with 0-wait ack -> the second op is accepted in the IDLE cycle after RESP, with no duplicate bus cycle during RESP.
